// File: rtl/min_stream_sort.sv
// Streaming min finder: merges each accepted beat of |LLR| lanes into a sorted list of the
// MIN_NUM smallest magnitudes (with global column index) and presents it at the row's last beat.
module min_stream_sort #(
    parameter int ABS_WID = 6,
    parameter int IN_NUM  = 4,
    parameter int MIN_NUM = 3,
    parameter int IDX_WID = 5
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_in_ready,
    input  logic [ABS_WID*IN_NUM-1:0]  i_data,
    input  logic [IN_NUM-1:0]          i_mask,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_out_ready,
    output logic [ABS_WID*MIN_NUM-1:0] o_data,
    output logic [IDX_WID*MIN_NUM-1:0] o_idx,
    output logic [IDX_WID:0]           o_fill,
    output logic                       o_ovf,
    output logic                       o_dbg_state
);

    // Handshake: a beat transfers on a rising edge with i_valid & o_in_ready; a result transfers
    // with o_valid & i_out_ready. o_valid and the result hold steady until that transfer.
    localparam int C_NUM  = MIN_NUM + IN_NUM;
    localparam int CNT_W  = IDX_WID + 1;
    localparam int FULL_W = CNT_W + $clog2(IN_NUM) + 1;
    localparam int FILL_W = IDX_WID + 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;
    state_t state, state_n;

    logic [ABS_WID-1:0] list_data [MIN_NUM];
    logic [IDX_WID-1:0] list_idx  [MIN_NUM];
    logic [MIN_NUM-1:0] list_vld;
    logic [CNT_W-1:0]   beat_cnt;
    logic               row_ovf;
    logic               accept;

    logic [ABS_WID-1:0] cand_val [C_NUM];
    logic [IDX_WID-1:0] cand_idx [C_NUM];
    logic [C_NUM-1:0]   cand_ok;
    logic [FULL_W-1:0]  lane_full;
    logic               lane_ovf;
    logic [ABS_WID:0]   key [C_NUM];
    int                 rank [C_NUM];
    logic [ABS_WID-1:0] m_data [MIN_NUM];
    logic [IDX_WID-1:0] m_idx  [MIN_NUM];
    logic [MIN_NUM-1:0] m_vld;
    logic [FILL_W-1:0]  m_fill;

    assign accept = i_valid & o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (accept) state_n = i_last ? S_IDLE : S_ACC;
    end

    always_comb begin
        o_in_ready  = ~o_valid | i_out_ready;
        o_dbg_state = state;
    end

    // Candidates: running list first (ignored outside a row), then the lanes in k order.
    always_comb begin
        lane_full = '0;
        lane_ovf  = 1'b0;
        for (int i = 0; i < MIN_NUM; i++) begin
            cand_val[i] = list_data[i];
            cand_idx[i] = list_idx[i];
            cand_ok[i]  = list_vld[i] & (state == S_ACC);
        end
        for (int k = 0; k < IN_NUM; k++) begin
            lane_full = FULL_W'(beat_cnt) * FULL_W'(IN_NUM) + FULL_W'(k);
            cand_val[MIN_NUM+k] = i_data[ABS_WID*k +: ABS_WID];
            cand_idx[MIN_NUM+k] = lane_full[IDX_WID-1:0];
            cand_ok[MIN_NUM+k]  = i_mask[k];
            if (i_mask[k] && (lane_full[FULL_W-1:IDX_WID] != '0)) lane_ovf = 1'b1;
        end
    end

    // Stable rank: empty candidates sort last; equal keys keep candidate order.
    always_comb begin
        for (int i = 0; i < C_NUM; i++) key[i] = {~cand_ok[i], cand_val[i]};
        for (int i = 0; i < C_NUM; i++) begin
            rank[i] = 0;
            for (int j = 0; j < C_NUM; j++) begin
                if ((j != i) && ((key[j] < key[i]) || ((key[j] == key[i]) && (j < i))))
                    rank[i] = rank[i] + 1;
            end
        end
    end

    always_comb begin
        m_fill = '0;
        for (int s = 0; s < MIN_NUM; s++) begin
            m_data[s] = '1;
            m_idx[s]  = '1;
            m_vld[s]  = 1'b0;
            for (int i = 0; i < C_NUM; i++) begin
                if ((rank[i] == s) && cand_ok[i]) begin
                    m_data[s] = cand_val[i];
                    m_idx[s]  = cand_idx[i];
                    m_vld[s]  = 1'b1;
                end
            end
            m_fill = m_fill + FILL_W'(m_vld[s]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int s = 0; s < MIN_NUM; s++) begin
                list_data[s] <= '1;
                list_idx[s]  <= '1;
            end
            list_vld <= '0;
            beat_cnt <= '0;
            row_ovf  <= 1'b0;
            o_valid  <= 1'b0;
            o_data   <= '1;
            o_idx    <= '1;
            o_fill   <= '0;
            o_ovf    <= 1'b0;
        end else begin
            if (o_valid && i_out_ready) o_valid <= 1'b0;
            if (accept) begin
                if (i_last) begin
                    o_valid <= 1'b1;
                    for (int s = 0; s < MIN_NUM; s++) begin
                        o_data[ABS_WID*s +: ABS_WID] <= m_data[s];
                        o_idx[IDX_WID*s +: IDX_WID]  <= m_idx[s];
                        list_data[s] <= '1;
                        list_idx[s]  <= '1;
                    end
                    o_fill   <= m_fill;
                    o_ovf    <= row_ovf | lane_ovf;
                    list_vld <= '0;
                    beat_cnt <= '0;
                    row_ovf  <= 1'b0;
                end else begin
                    for (int s = 0; s < MIN_NUM; s++) begin
                        list_data[s] <= m_data[s];
                        list_idx[s]  <= m_idx[s];
                    end
                    list_vld <= m_vld;
                    // Saturate so a very long row can never wrap back into legal indices.
                    if (beat_cnt != '1) beat_cnt <= beat_cnt + CNT_W'(1);
                    row_ovf <= row_ovf | lane_ovf;
                end
            end
        end
    end

endmodule
